// File: rtl/bus_pkg.sv
// Shared definitions for the memory bus arbiter: address map, size and
// target encodings, FSM state type, exception codes and lane helpers.
package bus_pkg;

  // Address map (inclusive bounds)
  localparam logic [31:0] DM_LO = 32'h0000_0000;
  localparam logic [31:0] DM_HI = 32'h0000_2FFF;
  localparam logic [31:0] T0_LO = 32'h0000_7F00;
  localparam logic [31:0] T0_HI = 32'h0000_7F0B;
  localparam logic [31:0] T1_LO = 32'h0000_7F10;
  localparam logic [31:0] T1_HI = 32'h0000_7F1B;
  localparam logic [31:0] IG_LO = 32'h0000_7F20;
  localparam logic [31:0] IG_HI = 32'h0000_7F23;

  // Timer registers that refuse word stores
  localparam logic [31:0] T0_RO_ADDR = 32'h0000_7F08;
  localparam logic [31:0] T1_RO_ADDR = 32'h0000_7F18;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_BYTE = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    TGT_DM     = 2'd0,
    TGT_TIMER0 = 2'd1,
    TGT_TIMER1 = 2'd2,
    TGT_IG     = 2'd3
  } tgt_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [4:0] EXC_NONE  = 5'd0;
  localparam logic [4:0] EXC_LOAD  = 5'd4;
  localparam logic [4:0] EXC_STORE = 5'd5;

  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

  // Byte lanes touched by an access of the given size at the given offset
  function automatic logic [3:0] lane_byteen(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    case (size)
      SIZE_WORD: return 4'b1111;
      SIZE_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_BYTE: return 4'b0001 << addr_lo;
      default:   return 4'b0000;
    endcase
  endfunction

  // Right-aligned store data copied onto every lane it could land in
  function automatic logic [31:0] lane_wdata(input logic [1:0]  size,
                                             input logic [31:0] wdata);
    case (size)
      SIZE_HALF: return {2{wdata[15:0]}};
      SIZE_BYTE: return {4{wdata[7:0]}};
      default:   return wdata;
    endcase
  endfunction

endpackage

// File: rtl/addr_check.sv
// Legality check and target decode for one bus request.
// Purely combinational; the arbiter registers its results with the request.
module addr_check
  import bus_pkg::*;
(
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  output logic        legal_o,
  output logic [1:0]  sel_o
);

  logic in_dm, in_t0, in_t1, in_ig, in_any, ro_word;

  assign in_dm   = in_range(addr_i, DM_LO, DM_HI);
  assign in_t0   = in_range(addr_i, T0_LO, T0_HI);
  assign in_t1   = in_range(addr_i, T1_LO, T1_HI);
  assign in_ig   = in_range(addr_i, IG_LO, IG_HI);
  assign in_any  = in_dm | in_t0 | in_t1 | in_ig;
  assign ro_word = we_i && ((addr_i == T0_RO_ADDR) || (addr_i == T1_RO_ADDR));

  // Decode the target window and apply the per-size alignment/range rules
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    legal_o = 1'b0;
    sel_o   = TGT_DM;
    if (in_t0)      sel_o = TGT_TIMER0;
    else if (in_t1) sel_o = TGT_TIMER1;
    else if (in_ig) sel_o = TGT_IG;

    case (size_e'(size_i))
      SIZE_WORD: legal_o = (addr_i[1:0] == 2'b00) && in_any && !ro_word;
      SIZE_HALF: legal_o = !addr_i[0] && (in_dm || in_ig);
      SIZE_BYTE: legal_o = in_dm || in_ig;
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: CPU M stage (port 0) and debug loader (port 1)
// share one target bus (DM, Timer0, Timer1, IG). Round-robin priority between
// simultaneous requests, programmable wait states, illegal accesses refused
// without touching the bus.
// Optional: define BUS_ERR_CNT_EN to add the saturating err_cnt output.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned DM_WAIT  = 1,
  parameter int unsigned DEV_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ready,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  output logic [4:0]  p0_exc,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ready,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [4:0]  p1_exc,
  output logic [1:0]  tgt_sel,
  output logic        tgt_en,
  output logic        tgt_we,
  output logic [31:0] tgt_addr,
  output logic [3:0]  tgt_byteen,
  output logic [31:0] tgt_wdata,
  input  logic [31:0] tgt_rdata
`ifdef BUS_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [3:0] DM_WAIT_C  = 4'(DM_WAIT);
  localparam logic [3:0] DEV_WAIT_C = 4'(DEV_WAIT);

  state_e      state_q;
  logic        gnt_q;      // port owning the current access
  logic        prio_q;     // port that wins a simultaneous request
  logic [3:0]  wait_q;     // remaining WAIT cycles after the current one

  logic        any_req, gnt_d;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        chk_legal;
  logic [1:0]  chk_sel;
  logic [3:0]  wait_len;

  logic        resp_fire, resp_port, resp_err;
  logic [4:0]  resp_exc;
  logic [31:0] resp_rdata;

  // Grant selection and the request fields that get latched in IDLE
  always_comb begin
    any_req   = p0_req | p1_req;
    gnt_d     = (p0_req && p1_req) ? prio_q : p1_req;
    req_we    = gnt_d ? p1_we    : p0_we;
    req_size  = gnt_d ? p1_size  : p0_size;
    req_addr  = gnt_d ? p1_addr  : p0_addr;
    req_wdata = gnt_d ? p1_wdata : p0_wdata;
  end

  // The check sits on the request as it is latched, so an illegal access can
  // go straight from IDLE to RESP without a bus cycle.
  addr_check u_addr_check (
    .we_i    (req_we),
    .size_i  (req_size),
    .addr_i  (req_addr),
    .legal_o (chk_legal),
    .sel_o   (chk_sel)
  );

  // Decide whether the coming edge enters RESP, and with what response
  always_comb begin
    wait_len   = (tgt_sel == TGT_DM) ? DM_WAIT_C : DEV_WAIT_C;
    resp_fire  = 1'b0;
    resp_port  = gnt_q;
    resp_err   = 1'b0;
    resp_exc   = EXC_NONE;
    resp_rdata = tgt_rdata;
    case (state_q)
      ST_IDLE: begin
        if (any_req && !chk_legal) begin
          resp_fire  = 1'b1;
          resp_port  = gnt_d;
          resp_err   = 1'b1;
          resp_exc   = req_we ? EXC_STORE : EXC_LOAD;
          resp_rdata = '0;
        end
      end
      ST_ACCESS: resp_fire = (wait_len == 4'd0);
      ST_WAIT:   resp_fire = (wait_q == 4'd0);
      default:   resp_fire = 1'b0;
    endcase
  end

  // Arbiter FSM with registered bus and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      prio_q     <= 1'b0;
      wait_q     <= '0;
      tgt_sel    <= '0;
      tgt_en     <= 1'b0;
      tgt_we     <= 1'b0;
      tgt_addr   <= '0;
      tgt_byteen <= '0;
      tgt_wdata  <= '0;
      p0_ready   <= 1'b0;
      p0_rdata   <= '0;
      p0_err     <= 1'b0;
      p0_exc     <= '0;
      p1_ready   <= 1'b0;
      p1_rdata   <= '0;
      p1_err     <= 1'b0;
      p1_exc     <= '0;
`ifdef BUS_ERR_CNT_EN
      err_cnt    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      tgt_en <= 1'b0;
      tgt_we <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            gnt_q      <= gnt_d;
            tgt_addr   <= req_addr;
            tgt_sel    <= chk_sel;
            tgt_byteen <= lane_byteen(req_size, req_addr[1:0]);
            tgt_wdata  <= lane_wdata(req_size, req_wdata);
            if (chk_legal) begin
              state_q <= ST_ACCESS;
              tgt_en  <= 1'b1;
              tgt_we  <= req_we;
            end else begin
              state_q <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (wait_len == 4'd0) begin
            state_q <= ST_RESP;
          end else begin
            wait_q  <= wait_len - 4'd1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_q == 4'd0) state_q <= ST_RESP;
          else                wait_q  <= wait_q - 4'd1;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          prio_q  <= ~gnt_q;
        end
        default: state_q <= ST_IDLE;
      endcase

      // Response registers are non-zero only during RESP, on the granted port
      p0_ready <= resp_fire && !resp_port;
      p0_rdata <= (resp_fire && !resp_port) ? resp_rdata : '0;
      p0_err   <= resp_fire && !resp_port && resp_err;
      p0_exc   <= (resp_fire && !resp_port) ? resp_exc : EXC_NONE;
      p1_ready <= resp_fire && resp_port;
      p1_rdata <= (resp_fire && resp_port) ? resp_rdata : '0;
      p1_err   <= resp_fire && resp_port && resp_err;
      p1_exc   <= (resp_fire && resp_port) ? resp_exc : EXC_NONE;

`ifdef BUS_ERR_CNT_EN
      if (resp_fire && resp_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
`endif
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter DM_WAIT, default 1: extra wait cycles for data-memory (DM) accesses (0..15).
REQ-002 SHALL have parameter DEV_WAIT, default 2: extra wait cycles for Timer0/Timer1/IG accesses (0..15).
REQ-003 SHALL use one clock and an asynchronous active-high reset; ports in order:
  clk  in  1  system clock
  reset  in  1  asynchronous active-high reset
  p0_req, p1_req  in  1 each  port 0 (CPU M stage) / port 1 (debug loader) request
  pN_we  in  1  1=store, 0=load
  pN_size  in  2  0=word, 1=half, 2=byte
  pN_addr  in  32  byte address
  pN_wdata  in  32  store data, right-aligned
  pN_ready  out  1  one-cycle completion pulse
  pN_rdata  out  32  raw 32-bit target read word, valid with ready
  pN_err  out  1  access refused, valid with ready
  pN_exc  out  5  4 = illegal load, 5 = illegal store, 0 = OK
  tgt_sel  out  2  0=DM, 1=Timer0, 2=Timer1, 3=IG
  tgt_en  out  1  target strobe
  tgt_we  out  1  target write
  tgt_addr  out  32  latched address
  tgt_byteen  out  4  byte lanes
  tgt_wdata  out  32  lane-replicated store data
  tgt_rdata  in  32  target read data

Function
REQ-004 SHALL implement FSM IDLE -> ACCESS -> WAIT -> RESP -> IDLE; IDLE -> RESP directly on an illegal access.
REQ-005 In IDLE with any req, SHALL grant one port, latch its we/size/addr/wdata at the clock edge, and ignore later changes.
REQ-006 Simultaneous requests: SHALL grant the port holding priority; after each completed grant, priority SHALL pass to the other port.
REQ-007 Legal ranges: DM 0x0000_0000-0x0000_2FFF; Timer0 0x7F00-0x7F0B; Timer1 0x7F10-0x7F1B; IG 0x7F20-0x7F23.
REQ-008 Word: address SHALL be 4-aligned and in any legal range; a word store to 0x7F08 or 0x7F18 SHALL be illegal.
REQ-009 Half: address SHALL be 2-aligned and in DM or IG; byte: address SHALL be in DM or IG.
REQ-010 Illegal access: SHALL never assert tgt_en; RESP follows on the next cycle with err=1 and exc=4 (load) or 5 (store).
REQ-011 ACCESS SHALL last exactly one cycle with tgt_en=1; WAIT SHALL last DM_WAIT or DEV_WAIT cycles and be skipped when the count is 0.
REQ-012 tgt_rdata SHALL be captured on the edge leaving the last ACCESS/WAIT cycle.
REQ-013 Legal-access latency: req sampled in cycle n, ACCESS in n+1, ready in n+2+W; illegal-access ready in n+1.
REQ-014 RESP SHALL last one cycle: ready, rdata, err and exc go to the granted port only; the other port's outputs SHALL be 0.
REQ-015 Each requester SHALL hold req until ready; req still high in the cycle after ready SHALL be treated as a new request.
REQ-016 tgt_byteen: word 1111; half addr[1] ? 1100 : 0011; byte 0001 << addr[1:0].
REQ-017 tgt_wdata: byte replicated x4, half replicated x2, word as-is.
REQ-018 tgt_* outputs SHALL hold the latched values from ACCESS through RESP; tgt_en and tgt_we SHALL be 0 outside ACCESS.

Reset
REQ-019 Reset SHALL force IDLE, priority to port 0, and all outputs to 0, at any time, including mid-access, with no ready pulse for an aborted access.

Configuration
REQ-020 With BUS_ERR_CNT_EN defined: output err_cnt[15:0] SHALL count RESP cycles with err=1, saturate at 0xFFFF, and reset to 0.
REQ-021 Without BUS_ERR_CNT_EN: no err_cnt port and no counter logic.

Structure
REQ-022 Package bus_pkg SHALL hold the range bounds, read-only timer addresses, size encodings, tgt_sel encodings, FSM state type and exception codes 4/5.
REQ-023 Legality check and target decode SHALL be a combinational sub-module addr_check, instanced once on the latched request.

Verification
REQ-024 p0 word load 0x0000_0010, DM_WAIT=1, tgt_rdata=0xDEADBEEF -> p0_ready 3 cycles after req, rdata 0xDEADBEEF, err=0.
REQ-025 p0 and p1 request together, twice -> p0 served first, then p1; tgt_en never asserted for both in one cycle.
REQ-026 p1 word store to 0x7F08 -> no tgt_en, p1_ready next cycle, err=1, exc=5; err_cnt=1 when BUS_ERR_CNT_EN is defined.
REQ-027 Half load 0x0000_0003 -> exc=4; byte store 0x7F21 data 0xAB -> tgt_byteen=0010, tgt_wdata=0xABABABAB, tgt_sel=3.
REQ-028 Reset asserted during WAIT of a Timer1 access -> no ready, all outputs 0, next request granted to port 0.
